// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/write-back slice: opcodes, widths
// and the instruction record carried through the instruction buffer.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned REG_AW = 3;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_NOR = 4'b0110;
  localparam logic [3:0] OP_SHL = 4'b0111;
  localparam logic [3:0] OP_SHR = 4'b1000;
  localparam logic [3:0] OP_ASR = 4'b1001;
  localparam logic [3:0] OP_ROL = 4'b1010;
  localparam logic [3:0] OP_ROR = 4'b1011;
  localparam logic [3:0] OP_EQ  = 4'b1100;

  typedef struct packed {
    logic [3:0]        ctrl;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              use_imm;
    logic [DATA_W-1:0] imm;
  } instr_t;

endpackage

// File: rtl/alu_issue_fifo.sv
// Synchronous instruction buffer; DEPTH must be a power of two >= 2 so the
// pointers wrap naturally.
module alu_issue_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  instr_t wdata_i,
  input  logic   pop_i,
  output instr_t rdata_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  instr_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage array; contents are don't-care while empty so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (!do_push && do_pop) count_q <= count_q - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/alu_issue_wb.sv
// Operand-issue and write-back stage around an external combinational ALU.
// Optional build macro ALU_FLAGS_EN adds registered zero/carry flag outputs.
module alu_issue_wb
  import alu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned NREG       = 8
) (
`ifdef ALU_FLAGS_EN
  output logic              flag_z,
  output logic              flag_c,
`endif
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_ctrl,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_carry
);

  instr_t            in_instr;
  instr_t            head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;

  logic              iss_valid_q;
  logic [REG_AW-1:0] iss_rd_q;
  logic [3:0]        ctrl_q;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic              fwd_rs, fwd_rt;

  assign in_instr = '{ctrl: in_ctrl, rd: in_rd, rs: in_rs, rt: in_rt,
                      use_imm: in_use_imm, imm: in_imm};
  assign in_ready = !fifo_full;
  assign pop      = !fifo_empty;

  alu_issue_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .wdata_i (in_instr),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Operand read: r0 is hard zero; the in-flight result bypasses the
  // register file because it is written on the same edge this issues.
  always_comb begin
    fwd_rs = iss_valid_q && (iss_rd_q != '0) && (iss_rd_q == head.rs);
    fwd_rt = iss_valid_q && (iss_rd_q != '0) && (iss_rd_q == head.rt);
    x_d = '0;
    y_d = '0;
    if (head.rs != '0) x_d = fwd_rs ? alu_out : regs_q[head.rs];
    if (head.use_imm)       y_d = head.imm;
    else if (head.rt != '0) y_d = fwd_rt ? alu_out : regs_q[head.rt];
  end

  // Issue register feeding the ALU; operands hold when nothing pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid_q <= 1'b0;
      iss_rd_q    <= '0;
      ctrl_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      iss_valid_q <= pop;
      if (pop) begin
        iss_rd_q <= head.rd;
        ctrl_q   <= head.ctrl;
        x_q      <= x_d;
        y_q      <= y_d;
      end
    end
  end

  assign alu_ctrl = ctrl_q;
  assign alu_x    = x_q;
  assign alu_y    = y_q;

  // Register file write of the retiring result; r0 stays zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (iss_valid_q && (iss_rd_q != '0)) begin
      regs_q[iss_rd_q] <= alu_out;
    end
  end

  // Registered write-back port; data holds between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      wb_carry <= 1'b0;
    end else begin
      wb_valid <= iss_valid_q;
      if (iss_valid_q) begin
        wb_rd    <= iss_rd_q;
        wb_data  <= alu_out;
        wb_carry <= alu_carry;
      end
    end
  end

`ifdef ALU_FLAGS_EN
  // Status flags track the most recent write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else if (iss_valid_q) begin
      flag_z <= (alu_out == '0);
      flag_c <= alu_carry;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_wb.sv
// Scoreboard bench for alu_issue_wb with a behavioural ALU attached.
module tb_alu_issue_wb;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_ctrl;
  logic [2:0] in_rd, in_rs, in_rt;
  logic       in_use_imm;
  logic [7:0] in_imm;
  logic [3:0] alu_ctrl;
  logic [7:0] alu_x, alu_y, alu_out;
  logic       alu_carry;
  logic       wb_valid;
  logic [2:0] wb_rd;
  logic [7:0] wb_data;
  logic       wb_carry;
`ifdef ALU_FLAGS_EN
  logic       flag_z, flag_c;
`endif

  always #5 clk = ~clk;

  alu_issue_wb #(.FIFO_DEPTH(2), .NREG(8)) dut (
`ifdef ALU_FLAGS_EN
    .flag_z     (flag_z),
    .flag_c     (flag_c),
`endif
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_rd      (in_rd),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_use_imm (in_use_imm),
    .in_imm     (in_imm),
    .alu_ctrl   (alu_ctrl),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_out    (alu_out),
    .alu_carry  (alu_carry),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .wb_carry   (wb_carry)
  );

  // Behavioural ALU: carry is the 9th bit for add, borrow for sub, else 0.
  logic [8:0]  r9;
  logic [15:0] t16;
  always_comb begin
    r9  = '0;
    t16 = {alu_x, alu_x};
    case (alu_ctrl)
      OP_ADD: r9 = {1'b0, alu_x} + {1'b0, alu_y};
      OP_SUB: r9 = {1'b0, alu_x} - {1'b0, alu_y};
      OP_AND: r9 = {1'b0, alu_x & alu_y};
      OP_OR:  r9 = {1'b0, alu_x | alu_y};
      OP_NOT: r9 = {1'b0, ~alu_x};
      OP_XOR: r9 = {1'b0, alu_x ^ alu_y};
      OP_NOR: r9 = {1'b0, ~(alu_x | alu_y)};
      OP_SHL: r9 = {1'b0, alu_x << alu_y[2:0]};
      OP_SHR: r9 = {1'b0, alu_x >> alu_y[2:0]};
      OP_ASR: r9 = {1'b0, $signed(alu_x) >>> alu_y[2:0]};
      OP_ROL: begin t16 = t16 << alu_y[2:0]; r9 = {1'b0, t16[15:8]}; end
      OP_ROR: begin t16 = t16 >> alu_y[2:0]; r9 = {1'b0, t16[7:0]}; end
      OP_EQ:  r9 = {8'h00, alu_x == alu_y};
      default: r9 = '0;
    endcase
  end
  assign alu_out   = r9[7:0];
  assign alu_carry = r9[8];

  typedef struct {
    logic [2:0]  rd;
    logic [7:0]  data;
    logic        carry;
    int unsigned cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Presents one instruction and holds it until accepted; in_valid stays
  // high so consecutive calls form a continuous stream.
  task automatic send(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                      input logic [2:0] rt, input logic ui, input logic [7:0] imm,
                      input logic [7:0] ed, input logic ec, input bit track);
    int w;
    in_valid = 1'b1; in_ctrl = op; in_rd = rd; in_rs = rs; in_rt = rt;
    in_use_imm = ui; in_imm = imm;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk("in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    if (track) sbq.push_back('{rd: rd, data: ed, carry: ec, cyc: cyc});
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every write-back pulse must match the oldest expectation,
  // arriving two cycles after its accept edge.
  always @(negedge clk) begin
    if (wb_valid) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_wb: got rd=%0d data=%02h expected no write-back", wb_rd, wb_data);
      end else begin
        e = sbq.pop_front();
        if (wb_rd !== e.rd || wb_data !== e.data || wb_carry !== e.carry || cyc != e.cyc + 2) begin
          bad++;
          $display("FAIL wb: got rd=%0d data=%02h c=%0b cyc=%0d expected rd=%0d data=%02h c=%0b cyc=%0d",
                   wb_rd, wb_data, wb_carry, cyc, e.rd, e.data, e.carry, e.cyc + 2);
        end
`ifdef ALU_FLAGS_EN
        total++;
        if (flag_z !== (e.data == 8'h00) || flag_c !== e.carry) begin
          bad++;
          $display("FAIL flags: got z=%0b c=%0b expected z=%0b c=%0b",
                   flag_z, flag_c, e.data == 8'h00, e.carry);
        end
`endif
      end
    end
  end

  task automatic chk_reset_state();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    chk("rst_alu_x", {24'd0, alu_x}, 32'd0);
    chk("rst_alu_y", {24'd0, alu_y}, 32'd0);
    chk("rst_wb_rd", {29'd0, wb_rd}, 32'd0);
    chk("rst_wb_data", {24'd0, wb_data}, 32'd0);
    chk("rst_wb_carry", {31'd0, wb_carry}, 32'd0);
`ifdef ALU_FLAGS_EN
    chk("rst_flag_z", {31'd0, flag_z}, 32'd0);
    chk("rst_flag_c", {31'd0, flag_c}, 32'd0);
`endif
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sbq.size() != 0 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk("drain_pending", sbq.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_rd = '0; in_rs = '0;
    in_rt = '0; in_use_imm = 1'b0; in_imm = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state();
    rst = 1'b0;

    // Immediate loads, then a dependent add that needs forwarding.
    send(OP_OR,  3'd1, 3'd0, 3'd0, 1'b1, 8'h05, 8'h05, 1'b0, 1'b1);
    send(OP_OR,  3'd2, 3'd0, 3'd0, 1'b1, 8'h03, 8'h03, 1'b0, 1'b1);
    send(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00, 8'h08, 1'b0, 1'b1);
    idle(3);

    // Carry out of add, borrow out of sub.
    send(OP_OR,  3'd4, 3'd0, 3'd0, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1);
    send(OP_OR,  3'd5, 3'd0, 3'd0, 1'b1, 8'h01, 8'h01, 1'b0, 1'b1);
    send(OP_ADD, 3'd6, 3'd4, 3'd5, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
    send(OP_SUB, 3'd7, 3'd5, 3'd4, 1'b0, 8'h00, 8'h02, 1'b1, 1'b1);
    idle(3);

    // Six-instruction continuous stream with chained dependencies.
    send(OP_XOR, 3'd1, 3'd1, 3'd0, 1'b1, 8'h0F, 8'h0A, 1'b0, 1'b1);
    send(OP_AND, 3'd2, 3'd1, 3'd0, 1'b1, 8'h06, 8'h02, 1'b0, 1'b1);
    send(OP_SHL, 3'd3, 3'd2, 3'd0, 1'b1, 8'h02, 8'h08, 1'b0, 1'b1);
    send(OP_NOT, 3'd4, 3'd3, 3'd0, 1'b1, 8'h00, 8'hF7, 1'b0, 1'b1);
    send(OP_NOR, 3'd5, 3'd4, 3'd2, 1'b0, 8'h00, 8'h08, 1'b0, 1'b1);
    send(OP_EQ,  3'd6, 3'd5, 3'd3, 1'b0, 8'h00, 8'h01, 1'b0, 1'b1);
    idle(3);

    // r0 write is reported but discarded, and must not be forwarded.
    send(OP_OR,  3'd0, 3'd0, 3'd0, 1'b1, 8'hAA, 8'hAA, 1'b0, 1'b1);
    send(OP_OR,  3'd1, 3'd0, 3'd0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
    idle(3);

    // 0x80 + 0x80: zero result with carry.
    send(OP_OR,  3'd1, 3'd0, 3'd0, 1'b1, 8'h80, 8'h80, 1'b0, 1'b1);
    send(OP_ADD, 3'd2, 3'd1, 3'd0, 1'b1, 8'h80, 8'h00, 1'b1, 1'b1);
    idle(3);
    drain();

    // Reset while two instructions are in flight: neither may retire.
    send(OP_OR,  3'd3, 3'd0, 3'd0, 1'b1, 8'h11, 8'h11, 1'b0, 1'b0);
    send(OP_OR,  3'd4, 3'd0, 3'd0, 1'b1, 8'h22, 8'h22, 1'b0, 1'b0);
    rst = 1'b1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state();
    rst = 1'b0;
    idle(3);

    // Every register must read back zero after reset.
    for (int k = 1; k < 8; k++)
      send(OP_OR, 3'd0, 3'(k), 3'd0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
    idle(4);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_issue_wb.md
Name: alu_issue_wb

Overview:
- Sequential operand-issue and write-back stage wrapped around the combinational 8-bit ALU (4-bit ctrl, x/y operands, {carry,out} result).
- Accepts register-form instructions through a valid/ready FIFO and reads operands from an internal 8x8 register file, with forwarding.
- Drives ctrl/x/y to the ALU from a registered issue stage, then captures {carry,out} into the register file and onto a registered write-back port.

Parameters:
- FIFO_DEPTH, 2, instruction buffer entries (power of 2, >=2).
- NREG, 8, register-file entries (index width = log2(NREG) = 3).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  FIFO not full; transfer when in_valid && in_ready.
- in_ctrl  in  4  ALU opcode (0000 add, 0001 sub, 0010 and, 0011 or, 0100 not, 0101 xor, 0110 nor, 0111 shl, 1000 shr, 1001 asr, 1010 rol, 1011 ror, 1100 eq, others give 0).
- in_rd  in  3  destination register.
- in_rs  in  3  x source register.
- in_rt  in  3  y source register.
- in_use_imm  in  1  y = in_imm instead of reg[in_rt].
- in_imm  in  8  immediate operand.
- alu_ctrl  out  4  to ALU ctrl.
- alu_x  out  8  to ALU x.
- alu_y  out  8  to ALU y.
- alu_out  in  8  from ALU out (combinational on alu_*).
- alu_carry  in  1  from ALU carry.
- wb_valid  out  1  one-cycle pulse per retired instruction.
- wb_rd  out  3  retired destination.
- wb_data  out  8  retired result.
- wb_carry  out  1  retired carry.

Behaviour:
- Reset (sync, active-high): FIFO empty, in_ready=1, issue valid=0, alu_ctrl=0, alu_x=0, alu_y=0, wb_valid=0, wb_rd=0, wb_data=0, wb_carry=0, all registers 0. Reset mid-operation drops every buffered and in-flight instruction; no write-back occurs on the reset edge.
- FIFO:
  - Push on in_valid && in_ready; pop whenever non-empty. The issue stage never stalls.
  - in_ready = !full. Push and pop in the same cycle are legal, count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Issue register: on pop, load ctrl, rd, and x/y:
  - x = reg[rs].
  - y = use_imm ? imm : reg[rt].
  - r0 always reads 0.
  - Forwarding: if issue valid && issue rd!=0 && issue rd==rs (or ==rt when !use_imm), take the current alu_out instead of reg[].
  - With no pop, issue valid clears and alu_ctrl/alu_x/alu_y hold their last values.
- Write-back: each cycle with issue valid:
  - reg[rd] <= alu_out; writes to r0 are ignored.
  - wb_valid <= 1; wb_rd/wb_data/wb_carry <= rd/alu_out/alu_carry.
  - Otherwise wb_valid <= 0 and the wb data outputs hold.
- Latency: accept edge N; issue loads at edge N+1 (alu_* valid during cycle N+1); wb_valid high during cycle N+2. Back-to-back throughput is 1 instruction/cycle.
- The register file is written at the same edge the next instruction issues. Forwarding covers that edge, so a dependent back-to-back pair needs no bubble.
- Widths: the carry comes only from the ALU (meaningful for add/sub); the block does no arithmetic of its own.

Optional Feature:
- ALU_FLAGS_EN defined: adds outputs flag_z (1 bit) and flag_c (1 bit).
  - Both reset to 0.
  - Updated on each write-back: flag_z = (alu_out==0), flag_c = alu_carry.
  - Hold when no write-back.
- ALU_FLAGS_EN undefined: the ports and flag logic are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - the 4-bit opcode localparams (OP_ADD..OP_EQ);
  - DATA_W=8 and REG_AW=3;
  - the instruction struct typedef {ctrl, rd, rs, rt, use_imm, imm}.
- One sub-module: alu_issue_fifo, a parameterised synchronous FIFO of instruction structs.
- The register file and forwarding stay inline.

Test Plan:
- Reset, then or r1,r0,#0x05 and or r2,r0,#0x03 -> wb_data 0x05 then 0x03; wb_valid high 2 cycles after each accept.
- add r3,r1,r2 issued back-to-back after the load of r2 -> forwarding gives wb_data=0x08, wb_carry=0.
- Load r4=0xFF, r5=0x01, then add r6,r4,r5 -> wb_data=0x00, wb_carry=1. sub r7,r5,r4 -> wb_data=0x02.
- Hold in_valid=1 continuously for 6 instructions -> 6 consecutive wb_valid pulses; check in_ready never drops and each rd/data is correct.
- Write to r0 (or r0,r0,#0xAA), then or r1,r0,#0 -> wb_data 0x00 for the second instruction.
- Assert rst mid-stream with 2 instructions buffered -> no wb_valid afterwards; all registers read 0. ALU_FLAGS_EN build: add 0x80+0x80 gives flag_z=1, flag_c=1.
